// File: rtl/weight_buf_pkg.sv
// Shared types, default sizes and flat-address helper for the weight buffer writer.
package weight_buf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } wbw_state_e;

  localparam int unsigned ROWS_DEF      = 64;
  localparam int unsigned COLS_DEF      = 64;
  localparam int unsigned NUM_BANKS_DEF = 10;
  localparam int unsigned W_DEF         = 32;
  localparam int unsigned A_DEF         = 12;

  // Row-major within a bank, banks stacked back to back.
  function automatic int unsigned flat_addr(input int unsigned bank, input int unsigned row,
                                            input int unsigned col, input int unsigned rows,
                                            input int unsigned cols);
    return (bank * rows + row) * cols + col;
  endfunction

endpackage

// File: rtl/wbw_addr_counter.sv
// Row/column walker for one bank: col fastest, wraps to (0,0) after the last word.
module wbw_addr_counter #(
  parameter int unsigned ROWS = 64,
  parameter int unsigned COLS = 64,
  parameter int unsigned A    = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [A-1:0] row,
  output logic [A-1:0] col,
  output logic         last
);

  localparam logic [A-1:0] ROW_LAST = A'(ROWS - 1);
  localparam logic [A-1:0] COL_LAST = A'(COLS - 1);

  logic col_wrap;

  assign col_wrap = (col == COL_LAST);
  assign last     = col_wrap && (row == ROW_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_wrap) begin
        col <= '0;
        // Wrapping back to row 0 lets CLEAR hand over to LOAD with zeroed counters.
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_buffer_writer.sv
// Streams weight words into one bank of the systolic-array weight store; registered read port.
// Optional build macro WEIGHT_BUF_ZERO_FILL_EN: zero the target bank before loading it.
module weight_buffer_writer
  import weight_buf_pkg::*;
#(
  parameter int unsigned ROWS      = ROWS_DEF,
  parameter int unsigned COLS      = COLS_DEF,
  parameter int unsigned NUM_BANKS = NUM_BANKS_DEF,
  parameter int unsigned W         = W_DEF,
  parameter int unsigned A         = A_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [A-1:0] bank_sel,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  input  logic [A-1:0] rd_bank,
  input  logic [A-1:0] rd_row,
  input  logic [A-1:0] rd_col,
  output logic [W-1:0] rd_data
);

  // Handshake: a word is consumed on a rising edge where in_valid && in_ready; in_ready only
  // depends on state, never on in_valid.

  localparam int unsigned DEPTH = NUM_BANKS * ROWS * COLS;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [A:0]  NB_LIM   = (A + 1)'(NUM_BANKS);
  localparam logic [A:0]  ROWS_LIM = (A + 1)'(ROWS);
  localparam logic [A:0]  COLS_LIM = (A + 1)'(COLS);

  if ((ROWS > (1 << A)) || (COLS > (1 << A)) || (NUM_BANKS > (1 << A))) begin : g_size_chk
    $error("weight_buffer_writer: ROWS, COLS and NUM_BANKS must each fit in A address bits");
  end

  wbw_state_e     state_q, state_d;
  logic [A-1:0]   bank_q;
  logic           bank_ld;
  logic           err_q, err_d;
  logic           cnt_clr, cnt_en, cnt_last;
  logic [A-1:0]   row, col;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic [AW-1:0]  wr_addr, rd_addr;
  logic           bank_ok, rd_in_range;

  logic [W-1:0]   mem [DEPTH];

  wbw_addr_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .A    (A)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .row  (row),
    .col  (col),
    .last (cnt_last)
  );

  assign bank_ok = ({1'b0, bank_sel} < NB_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bank_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (bank_ld) bank_q <= bank_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    bank_ld = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    wr_en   = 1'b0;
    wr_data = in_data;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bank_ok) begin
            bank_ld = 1'b1;
            cnt_clr = 1'b1;
`ifdef WEIGHT_BUF_ZERO_FILL_EN
            state_d = CLEAR;
`else
            state_d = LOAD;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
`ifdef WEIGHT_BUF_ZERO_FILL_EN
      CLEAR: begin
        wr_en   = 1'b1;
        wr_data = '0;
        cnt_en  = 1'b1;
        if (cnt_last) state_d = LOAD;
      end
`endif
      LOAD: begin
        if (in_valid) begin
          wr_en  = 1'b1;
          cnt_en = 1'b1;
          if (cnt_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;

  assign wr_addr = AW'(flat_addr(32'(bank_q), 32'(row), 32'(col), ROWS, COLS));
  assign rd_addr = AW'(flat_addr(32'(rd_bank), 32'(rd_row), 32'(rd_col), ROWS, COLS));

  assign rd_in_range = ({1'b0, rd_bank} < NB_LIM) && ({1'b0, rd_row} < ROWS_LIM) &&
                       ({1'b0, rd_col} < COLS_LIM);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Non-blocking read of the array gives old data on a same-cycle read/write collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= rd_in_range ? mem[rd_addr] : '0;
  end

endmodule

// File: tb/tb_weight_buffer_writer.sv
// Randomised scoreboard bench for weight_buffer_writer against an array model of the store.
module tb_weight_buffer_writer;

  localparam int ROWS = 64;
  localparam int COLS = 64;
  localparam int NB   = 10;
  localparam int W    = 32;
  localparam int A    = 12;
  localparam int N    = ROWS * COLS;
  localparam int DEPTH = NB * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [A-1:0] bank_sel;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready, busy, done, err;
  logic [A-1:0] rd_bank, rd_row, rd_col;
  logic [W-1:0] rd_data;

  weight_buffer_writer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bank_sel (bank_sel),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rd_bank  (rd_bank),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] ref_mem [DEPTH];
  bit           known   [DEPTH];
  bit rd_en_tb = 1'b0;
  bit rd_armed = 1'b0;
  int done_cnt = 0, err_cnt = 0, busy_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int fidx(input int b, input int r, input int c);
    return (b * ROWS + r) * COLS + c;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) rd_armed <= rd_en_tb;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (rd_armed) begin
      if (exp_q.size() == 0) check("rd_queue_underflow", 32'd1, 32'd0);
      else check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_pulse();
    @(posedge clk) #1;
    rst = 1'b1; in_valid = 1'b0; start = 1'b0; rd_en_tb = 1'b0;
    #1;
    check("reset_in_ready", W'(in_ready), 0);
    check("reset_busy", W'(busy), 0);
    check("reset_done", W'(done), 0);
    check("reset_err", W'(err), 0);
    check("reset_rd_data", rd_data, 0);
    @(posedge clk) #1;
    rst = 1'b0;
  endtask

  task automatic issue_read(input int b, input int r, input int c, input logic [W-1:0] exp);
    @(posedge clk) #1;
    rd_bank = A'(b); rd_row = A'(r); rd_col = A'(c);
    rd_en_tb = 1'b1;
    @(negedge clk);
    exp_q.push_back(exp);
  endtask

  task automatic read_idle();
    @(posedge clk) #1;
    rd_en_tb = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_reads(input int n);
    int b, r, c;
    bit found;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        b = $urandom_range(0, NB - 1); r = $urandom_range(0, ROWS - 1); c = $urandom_range(0, COLS - 1);
        case ($urandom_range(0, 2))
          0: b = $urandom_range(NB, 4095);
          1: r = $urandom_range(ROWS, 4095);
          default: c = $urandom_range(COLS, 4095);
        endcase
        issue_read(b, r, c, '0);
      end else begin
        found = 1'b0;
        for (int t = 0; t < 200 && !found; t++) begin
          b = $urandom_range(0, NB - 1); r = $urandom_range(0, ROWS - 1); c = $urandom_range(0, COLS - 1);
          found = known[fidx(b, r, c)];
        end
        if (found) issue_read(b, r, c, ref_mem[fidx(b, r, c)]);
      end
    end
    read_idle();
  endtask

  // vmode: 0 continuous valid, 1 valid on odd LOAD cycles, 2 random valid.
  task automatic load(input int bank, input int nwords, input int vmode, input bit seq_data,
                      input bit shadow, input bit poke, input int dead_idx, output int cycles);
    int k, bad, idx, e0;
    bit v;
    k = 0; bad = 0; e0 = err_cnt;
    @(posedge clk) #1;
    start = 1'b1; bank_sel = A'(bank);
`ifdef WEIGHT_BUF_ZERO_FILL_EN
    @(posedge clk) #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
      if (i < N - 1) @(posedge clk);
    end
    for (int i = 0; i < N; i++) begin
      ref_mem[fidx(bank, 0, 0) + i] = '0;
      known[fidx(bank, 0, 0) + i] = 1'b1;
    end
    check("clear_window", W'(bad), 0);
    bad = 0;
`endif
    cycles = 0;
    while (k < nwords && cycles < 4 * N) begin
      @(posedge clk) #1;
      case (vmode)
        0: v = 1'b1;
        1: v = ((cycles % 2) == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      idx = fidx(bank, 0, 0) + k;
      in_valid = v;
      in_data = (k == dead_idx) ? W'(32'hDEAD) : (seq_data ? W'(k) : W'($urandom));
      start = poke ? ($urandom_range(0, 7) == 0) : 1'b0;
      bank_sel = poke ? A'($urandom_range(0, 4095)) : A'(bank);
      if (shadow) begin
        rd_bank = A'(bank); rd_row = A'(k / COLS); rd_col = A'(k % COLS);
        rd_en_tb = known[idx];
      end
      @(negedge clk);
      if (in_ready !== 1'b1) bad++;
      if (shadow && known[idx]) exp_q.push_back(ref_mem[idx]);
      if (v && in_ready === 1'b1) begin
        ref_mem[idx] = in_data;
        known[idx] = 1'b1;
        k++;
      end
      cycles++;
    end
    @(posedge clk) #1;
    in_valid = 1'b0; start = 1'b0; rd_en_tb = 1'b0;
    check("in_ready_window", W'(bad), 0);
    check("words_accepted", W'(k), W'(nwords));
    if (poke) check("start_ignored_in_load", W'(err_cnt - e0), 0);
    if (nwords == N) begin
      @(negedge clk);
      check("done_pulse", W'(done), 1);
      check("in_ready_in_done", W'(in_ready), 0);
      @(posedge clk) #1;
      @(negedge clk);
      check("done_one_cycle", W'(done), 0);
      check("idle_after_done", W'(busy), 0);
    end
  endtask

  task automatic err_start(input int bsel);
    int e0, b0, d0;
    e0 = err_cnt; b0 = busy_cnt; d0 = done_cnt;
    @(posedge clk) #1;
    start = 1'b1; bank_sel = A'(bsel);
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", W'(err), 1);
    @(posedge clk) #1;
    @(negedge clk);
    check("err_one_cycle", W'(err), 0);
    check("err_count", W'(err_cnt - e0), 1);
    check("busy_on_err", W'(busy_cnt - b0), 0);
    check("done_on_err", W'(done_cnt - d0), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, d0;
    rst = 1'b1; start = 1'b0; bank_sel = '0; in_valid = 1'b0; in_data = '0;
    rd_bank = '0; rd_row = '0; rd_col = '0;
    @(negedge clk);
    check("reset_in_ready", W'(in_ready), 0);
    check("reset_busy", W'(busy), 0);
    check("reset_done", W'(done), 0);
    check("reset_err", W'(err), 0);
    check("reset_rd_data", rd_data, 0);
    @(posedge clk) #1;
    rst = 1'b0;

    // Bank 0, sequential data, continuous stream
    d0 = done_cnt;
    load(0, N, 0, 1'b1, 1'b0, 1'b0, -1, cyc);
    check("load_cycles_continuous", W'(cyc), W'(N));
    check("done_count_b0", W'(done_cnt - d0), 1);
    issue_read(0, 0, 0, 0);
    issue_read(0, 1, 0, 64);
    issue_read(0, 63, 63, 4095);
    read_idle();

    // Bank 3, valid toggling
    load(3, N, 1, 1'b1, 1'b0, 1'b0, -1, cyc);
    check("load_cycles_toggle", W'(cyc), W'(2 * N));
    issue_read(3, 2, 5, 133);
    issue_read(0, 63, 63, 4095);
    read_idle();
    rand_reads(30);

    // Invalid bank selects
    err_start(NB);
    err_start($urandom_range(NB + 1, 4095));
    rand_reads(20);

    // Bank 7, random data and valid, stray start pulses during LOAD
    load(7, N, 2, 1'b0, 1'b0, 1'b1, -1, cyc);
    rand_reads(40);

    // Reset after 100 words, then reload
    d0 = done_cnt;
    load(5, 100, 0, 1'b0, 1'b0, 1'b0, -1, cyc);
    reset_pulse();
    @(negedge clk);
    check("busy_after_abort", W'(busy), 0);
    check("no_done_on_abort", W'(done_cnt - d0), 0);
    issue_read(5, 1, 35, ref_mem[fidx(5, 1, 35)]);
    read_idle();
    load(5, N, 2, 1'b0, 1'b0, 1'b0, -1, cyc);
    rand_reads(30);

    // Reload bank 0 while reading each address as it is written
    load(0, N, 0, 1'b0, 1'b1, 1'b0, 7, cyc);
    read_idle();
    issue_read(0, 0, 7, 32'hDEAD);
    issue_read(0, 64, 0, 0);
    read_idle();

`ifdef WEIGHT_BUF_ZERO_FILL_EN
    load(0, 10, 0, 1'b0, 1'b0, 1'b0, -1, cyc);
    reset_pulse();
    issue_read(0, 0, 10, 0);
    issue_read(0, 63, 63, 0);
    issue_read(0, 0, 9, ref_mem[fidx(0, 0, 9)]);
    read_idle();
    rand_reads(30);
`endif

    repeat (3) @(posedge clk);
    check("exp_q_drained", W'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
